// File: rtl/mips_pkg.sv
// Shared opcode constants, issue FSM encoding and opcode legality check.
// Imported by instr_issue and by MainControl, which decodes the same opcodes.
package mips_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_ISSUE,
        S_DONE
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                          OP_ADDI, OP_SLT, OP_HALT};
    endfunction

endpackage

// File: rtl/instr_issue.sv
// Fetch/issue unit: fetches 16-bit words, splits Op/rs/rt/rd_imm, and
// hands them downstream over valid/ready; stops on HALT or illegal opcode.
// Ports: clk, rst_n (sync, active-low), start/start_addr, imem_en/
// imem_addr/imem_rdata, op_valid/op_ready, Op/rs/rt/rd_imm, pc, busy,
// halted, err.
module instr_issue
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [3:0]        Op,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [3:0]        rd_imm,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [15:0] ir;
    logic [3:0]  rd_op;

    assign rd_op     = imem_rdata[15:12];
    assign imem_addr = pc;
    assign Op        = ir[15:12];
    assign rs        = ir[11:8];
    assign rt        = ir[7:4];
    assign rd_imm    = ir[3:0];

    // Control outputs are registered alongside the state so none of
    // them depends combinationally on op_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            op_valid <= 1'b0;
            imem_en  <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_REQ;
                        pc      <= start_addr;
                        halted  <= 1'b0;
                        err     <= 1'b0;
                        imem_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_REQ: begin
                    imem_en <= 1'b0;
                    state   <= S_DATA;
                end
                S_DATA: begin
                    ir <= imem_rdata;
                    if (!op_is_legal(rd_op)) begin
                        state <= S_DONE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (rd_op == OP_HALT) begin
                        state  <= S_DONE;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state    <= S_ISSUE;
                        op_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        pc       <= pc + PC_ONE;
                        imem_en  <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Scoreboard bench for instr_issue: directed programs in a model memory,
// expected issues queued by the stimulus and checked by a monitor.
module tb_instr_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_addr;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  Op, rs, rt, rd_imm;
    logic [7:0]  pc;
    logic        busy, halted, err;

    instr_issue #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .op_valid(op_valid), .op_ready(op_ready), .Op(Op), .rs(rs),
        .rt(rt), .rd_imm(rd_imm), .pc(pc), .busy(busy), .halted(halted),
        .err(err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    typedef struct {
        logic [15:0] w;
        logic [7:0]  a;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_issue = 0;
    int   bad_op = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor samples mid-low-phase, after the bench has driven inputs.
    always begin
        @(negedge clk);
        #2;
        if (op_valid && (Op == 4'h5 || Op == 4'h6 ||
                         (Op >= 4'h8 && Op <= 4'hE)))
            bad_op++;
        if (op_valid && op_ready) begin
            n_issue++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {Op, rs, rt, rd_imm}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_word", {Op, rs, rt, rd_imm}, e.w);
                check("issue_pc", pc, e.a);
            end
        end
    end

    task automatic pulse_start(input logic [7:0] a);
        start_addr = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!(halted || err) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(nm, halted | err, 1);
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (!op_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(nm, op_valid, 1);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_outs"},
              {op_valid, imem_en, busy, halted, err}, 0);
        check({nm, "_fields"}, {Op, rs, rt, rd_imm}, 0);
        check({nm, "_pc"}, pc, 0);
    endtask

    initial begin
        int n0;
        logic [15:0] prog [7];
        prog = '{16'h0123, 16'h1456, 16'h2789, 16'h3ABC,
                 16'h4DEF, 16'h7012, 16'hF000};
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst_n = 1'b0;
        start = 1'b0;
        start_addr = 8'h00;
        op_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Program run with op_ready high
        for (int i = 0; i < 7; i++) mem[8'h10 + i] = prog[i];
        for (int i = 0; i < 6; i++)
            exp_q.push_back('{w: prog[i], a: 8'(8'h10 + i)});
        op_ready = 1'b1;
        hs_cyc.delete();
        pulse_start(8'h10);
        check("t1_req_en", imem_en, 1);
        check("t1_req_addr", imem_addr, 8'h10);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_data_novalid", op_valid, 0);
        @(negedge clk);
        check("t1_first_valid", op_valid, 1);
        wait_done("t1_done");
        check("t1_halted", halted, 1);
        check("t1_err", err, 0);
        check("t1_busy_low", busy, 0);
        check("t1_pc", pc, 8'h16);
        check("t1_issues", hs_cyc.size(), 6);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("t1_gap", hs_cyc[i] - hs_cyc[i-1], 3);

        // Backpressure, plus a start pulse while busy
        mem[8'h20] = 16'h0123;
        mem[8'h21] = 16'hF000;
        mem[8'h40] = 16'h7777;
        op_ready = 1'b0;
        exp_q.push_back('{w: 16'h0123, a: 8'h20});
        n0 = n_issue;
        pulse_start(8'h20);
        wait_valid("t2_valid");
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", op_valid, 1);
            check("t2_hold_word", {Op, rs, rt, rd_imm}, 16'h0123);
            check("t2_hold_pc", pc, 8'h20);
            if (i == 1) begin
                start_addr = 8'h40;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        op_ready = 1'b1;
        wait_done("t2_done");
        check("t2_issues", n_issue - n0, 1);
        check("t2_halted", halted, 1);
        check("t2_pc", pc, 8'h21);

        // Illegal opcode, restart from DONE clears halted
        mem[8'h30] = 16'h1456;
        mem[8'h31] = 16'h5000;
        exp_q.push_back('{w: 16'h1456, a: 8'h30});
        n0 = n_issue;
        pulse_start(8'h30);
        check("t3_halted_clr", halted, 0);
        wait_done("t3_done");
        check("t3_err", err, 1);
        check("t3_halted", halted, 0);
        check("t3_busy", busy, 0);
        check("t3_pc", pc, 8'h31);
        check("t3_issues", n_issue - n0, 1);

        // PC wrap, restart clears err
        mem[8'hFF] = 16'h0000;
        mem[8'h00] = 16'hF000;
        exp_q.push_back('{w: 16'h0000, a: 8'hFF});
        pulse_start(8'hFF);
        check("t4_err_clr", err, 0);
        check("t4_addr", imem_addr, 8'hFF);
        begin
            int k = 0;
            @(negedge clk);
            while (!imem_en && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        check("t4_fetch_en", imem_en, 1);
        check("t4_fetch_addr", imem_addr, 8'h00);
        wait_done("t4_done");
        check("t4_halted", halted, 1);
        check("t4_pc", pc, 8'h00);

        // Reset while an issue is pending
        mem[8'h50] = 16'h3ABC;
        op_ready = 1'b0;
        pulse_start(8'h50);
        wait_valid("t5_valid");
        check("t5_word", {Op, rs, rt, rd_imm}, 16'h3ABC);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("t5_reset");
        rst_n = 1'b1;
        op_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_idle", {op_valid, busy, imem_en}, 0);

        check("queue_empty", exp_q.size(), 0);
        check("no_illegal_issue", bad_op, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
# instr_issue

Sequential instruction fetch/issue unit that drives the 4-bit `Op` input of `MainControl`. It fetches 16-bit instruction words from a synchronous instruction memory and splits off the opcode and register fields. It presents them downstream with a valid/ready handshake and stops cleanly on HALT or on an illegal opcode. It is the producer side of the opcode interface that `MainControl` consumes.

## Interface
- `ADDR_W`, default 8: instruction memory address width.
- `clk`  in  1: single clock; every register updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `start`  in  1: one-cycle request to begin fetching at `start_addr`. Ignored while `busy`.
- `start_addr`  in  ADDR_W: first fetch address.
- `imem_en`  out  1: memory read strobe.
- `imem_addr`  out  ADDR_W: memory read address. Equals `pc`.
- `imem_rdata`  in  16: read data, valid exactly one cycle after `imem_en`.
- `op_valid`  out  1: issued instruction fields are valid.
- `op_ready`  in  1: downstream accepts the fields.
- `Op`  out  4: opcode, instr[15:12].
- `rs`, `rt`, `rd_imm`  out  4 each: instr[11:8], instr[7:4], instr[3:0].
- `pc`  out  ADDR_W: address of the instruction currently fetched or issued.
- `busy`  out  1: high in REQ, DATA and ISSUE.
- `halted`  out  1: sticky, set by HALT.
- `err`  out  1: sticky, set by an illegal opcode.

## Operation
- Legal opcodes: add 0000, sub 0001, and 0010, or 0011, addi 0100, slt 0111, HALT 1111.
- Illegal opcodes: 0101, 0110, 1000–1110.
- FSM states:
  - IDLE:
    - `start`=1 → REQ.
    - Load `pc`←`start_addr`.
    - Clear `halted` and `err`.
  - REQ:
    - `imem_en`=1.
    - Go to DATA unconditionally.
  - DATA:
    - Capture `imem_rdata` into the instruction register.
    - Legal, non-HALT opcode → ISSUE.
    - HALT → DONE and set `halted`.
    - Illegal opcode → DONE and set `err`.
  - ISSUE:
    - `op_valid`=1; `Op`, `rs`, `rt`, `rd_imm` come from the instruction register.
    - Hold all fields stable until `op_ready`=1.
    - On handshake: `pc`←`pc`+1 → REQ.
  - DONE:
    - `busy`=0.
    - `start`=1 → same actions as IDLE+`start` (restart).
- HALT and illegal words are never presented with `op_valid`=1.
- `pc` increment is modulo 2^ADDR_W: all-ones wraps to 0. No error is raised on wrap.
- `op_valid` never drops without a handshake. Fields change only after a handshake.
- `start` asserted in REQ, DATA or ISSUE has no effect.
- Reset (`rst_n`=0 at an edge), from any state including mid-ISSUE, gives next cycle:
  - state IDLE;
  - `pc`=0, instruction register=0;
  - `op_valid`=0, `imem_en`=0, `busy`=0, `halted`=0, `err`=0;
  - `Op`/`rs`/`rt`/`rd_imm`=0.
- A pending downstream transfer at reset is dropped.

## Timing
- Edge T samples `start`=1.
- Cycle T+1: REQ, with `imem_en`=1 and `imem_addr`=`start_addr`.
- Cycle T+2: DATA; `imem_rdata` is valid and is registered at the end of the cycle.
- Cycle T+3: ISSUE, `op_valid`=1.
- Start to first `op_valid`: 3 cycles.
- With `op_ready` held high, one instruction issues every 3 cycles.
- Each cycle of `op_ready`=0 in ISSUE adds one cycle.
- HALT or illegal word: `halted` or `err` rises at T+3 relative to its REQ-cycle-minus-one reference.
  - That is, one cycle after its DATA cycle.
  - `busy` falls in that same cycle.
- All outputs are registered or decoded from state only. No combinational path from `op_ready` to any output.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_ADDI`, `OP_SLT`, `OP_HALT`;
  - the FSM state encoding (IDLE, REQ, DATA, ISSUE, DONE);
  - function `op_is_legal(op)`.
- `MainControl` uses the same opcode constants.
- No sub-module is needed. The FSM, `pc` and instruction register live in one module.

## Test plan
- Memory at 0x10–0x16 = 0x0123, 0x1456, 0x2789, 0x3ABC, 0x4DEF, 0x7012, 0xF000. `start` with `start_addr`=0x10 and `op_ready`=1:
  - Op sequence 0000, 0001, 0010, 0011, 0100, 0111 issues with `rs`/`rt`/`rd_imm` matching the words.
  - Issues are 3 cycles apart.
  - Then `halted`=1, `busy`=0, `pc`=0x16.
- Backpressure: `op_ready`=0 for 5 cycles during the first ISSUE → `Op`/fields/`pc` stable for all 5 cycles; a single issue on release.
- Illegal word 0x5000 at the second address → one issue only, then `err`=1, `halted`=0, and 0x5 never appears with `op_valid`=1.
- Wrap: `start_addr`=0xFF holding 0x0000, address 0x00 holding 0xF000 → issue at `pc`=0xFF, then fetch at `imem_addr`=0x00, then `halted`.
- Reset mid-ISSUE (`rst_n`=0 one cycle) → next cycle all outputs 0 in IDLE. A second `start` while busy is ignored; `start` in DONE restarts and clears `halted`/`err`.
